// File: rtl/dti_monitor.sv
// dti_monitor: passive multi-channel valid/ready/data protocol monitor.
// Counts handshakes, tracks stalls, and raises sticky hold-rule and timeout
// flags, capturing the first channel to report an error.
module dti_monitor #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 256,
  parameter int SATURATE = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic                                            clr,
  input  logic [NUM_CH-1:0]                               valid,
  input  logic [NUM_CH-1:0]                               ready,
  input  logic [NUM_CH*DATA_W-1:0]                        data,
  output logic [NUM_CH*CNT_W-1:0]                         hs_cnt,
  output logic [NUM_CH-1:0]                               pending,
  output logic [NUM_CH-1:0]                               err_hold,
  output logic [NUM_CH-1:0]                               err_timeout,
  output logic                                            err_any,
  output logic                                            first_err_vld,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  first_err_ch
);

  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STALL_MAX = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam int STALL_W   = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q   [NUM_CH];
  state_t              state_d   [NUM_CH];
  logic [DATA_W-1:0]   lat_q     [NUM_CH];
  logic [DATA_W-1:0]   d_cur     [NUM_CH];
  logic [STALL_W-1:0]  stall_q   [NUM_CH];
  logic [STALL_W-1:0]  stall_nxt [NUM_CH];
  logic [CNT_W-1:0]    cnt_q     [NUM_CH];
  logic [CNT_W-1:0]    cnt_inc   [NUM_CH];

  logic [NUM_CH-1:0]   stalled;
  logic [NUM_CH-1:0]   hs_ev;
  logic [NUM_CH-1:0]   hold_ev;
  logic [NUM_CH-1:0]   to_ev;
  logic [NUM_CH-1:0]   latch_ev;
  logic [NUM_CH-1:0]   hold_nxt;
  logic [NUM_CH-1:0]   to_nxt;
  logic                first_hit;
  logic [CH_W-1:0]     first_idx;

  // Per-channel FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any enabled stalled edge leaves the channel in WAIT, everything
  // else (handshake, valid drop, monitor disabled) returns it to IDLE.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = IDLE;
      case (state_q[i])
        IDLE:    if (stalled[i]) state_d[i] = WAIT;
        WAIT:    if (stalled[i]) state_d[i] = WAIT;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Per-channel events, next flag values, first-error arbitration and output decode.
  always_comb begin
    hs_cnt    = '0;
    pending   = '0;
    stalled   = '0;
    hs_ev     = '0;
    hold_ev   = '0;
    to_ev     = '0;
    latch_ev  = '0;
    first_hit = 1'b0;
    first_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      d_cur[i]     = data[i*DATA_W +: DATA_W];
      stalled[i]   = en & valid[i] & ~ready[i];
      hs_ev[i]     = en & valid[i] & ready[i];
      hold_ev[i]   = en && (state_q[i] == WAIT) && (!valid[i] || (d_cur[i] != lat_q[i]));
      latch_ev[i]  = stalled[i] && ((state_q[i] == IDLE) || (d_cur[i] != lat_q[i]));
      stall_nxt[i] = (state_q[i] == IDLE) ? STALL_W'(1)
                   : (stall_q[i] == STALL_LIM) ? stall_q[i] : stall_q[i] + 1'b1;
      // Fires only on the edge the counter arrives at the limit, not while parked there.
      to_ev[i]     = (TIMEOUT > 0) && stalled[i] && (stall_nxt[i] == STALL_LIM)
                     && (stall_q[i] != STALL_LIM);
      cnt_inc[i]   = ((SATURATE != 0) && (cnt_q[i] == '1)) ? cnt_q[i] : cnt_q[i] + 1'b1;
      pending[i]   = (state_q[i] == WAIT);
      hs_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      if ((hold_ev[i] || to_ev[i]) && !first_hit) begin
        first_hit = 1'b1;
        first_idx = CH_W'(i);
      end
    end
    hold_nxt = clr ? '0 : (err_hold | hold_ev);
    to_nxt   = clr ? '0 : (err_timeout | to_ev);
  end

  // Datapath: latched data, stall counters, handshake counters, sticky flags, capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        lat_q[i]   <= '0;
        stall_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      err_hold      <= '0;
      err_timeout   <= '0;
      err_any       <= 1'b0;
      first_err_vld <= 1'b0;
      first_err_ch  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (latch_ev[i]) lat_q[i] <= d_cur[i];
        stall_q[i] <= stalled[i] ? stall_nxt[i] : '0;
        if (clr)           cnt_q[i] <= '0;
        else if (hs_ev[i]) cnt_q[i] <= cnt_inc[i];
      end
      err_hold    <= hold_nxt;
      err_timeout <= to_nxt;
      err_any     <= |{hold_nxt, to_nxt};
      if (clr) begin
        first_err_vld <= 1'b0;
        first_err_ch  <= '0;
      end else if (!first_err_vld && first_hit) begin
        first_err_vld <= 1'b1;
        first_err_ch  <= first_idx;
      end
    end
  end

endmodule

// File: tb/tb_dti_monitor.sv
// tb_dti_monitor: table-driven scoreboard bench for dti_monitor.
// Two instances share stimulus: saturating and wrapping 3-bit counters, TIMEOUT=4.
module tb_dti_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [63:0] data;

  logic [11:0] hs_s,   hs_w;
  logic [3:0]  pend_s, pend_w;
  logic [3:0]  eh_s,   eh_w;
  logic [3:0]  et_s,   et_w;
  logic        ea_s,   ea_w;
  logic        fv_s,   fv_w;
  logic [1:0]  fch_s,  fch_w;

  int errors = 0;
  int checks = 0;
  int cur_vec = 0;

  typedef struct {
    logic        en;
    logic        clr;
    logic [3:0]  v;
    logic [3:0]  r;
    logic [63:0] d;
    logic [11:0] hs;
    logic [11:0] hsw;
    logic [3:0]  pend;
    logic [3:0]  eh;
    logic [3:0]  et;
    logic        ea;
    logic        fv;
    logic [1:0]  fch;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  localparam logic [63:0] D1  = 64'h0000_0000_A5A5_0000;
  localparam logic [63:0] D1B = 64'h0000_0000_1234_0000;
  localparam logic [63:0] D2A = 64'h0000_1111_0000_0000;
  localparam logic [63:0] D2B = 64'h0000_2222_0000_0000;

  dti_monitor #(.NUM_CH(4), .DATA_W(16), .CNT_W(3), .TIMEOUT(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .ready(ready), .data(data),
    .hs_cnt(hs_s), .pending(pend_s), .err_hold(eh_s), .err_timeout(et_s),
    .err_any(ea_s), .first_err_vld(fv_s), .first_err_ch(fch_s)
  );

  dti_monitor #(.NUM_CH(4), .DATA_W(16), .CNT_W(3), .TIMEOUT(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid), .ready(ready), .data(data),
    .hs_cnt(hs_w), .pending(pend_w), .err_hold(eh_w), .err_timeout(et_w),
    .err_any(ea_w), .first_err_vld(fv_w), .first_err_ch(fch_w)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  function automatic vec_t mk(input logic en_i, input logic clr_i,
                              input logic [3:0] v_i, input logic [3:0] r_i,
                              input logic [63:0] d_i, input logic [11:0] hs_i,
                              input logic [3:0] pend_i, input logic [3:0] eh_i,
                              input logic [3:0] et_i, input logic ea_i,
                              input logic fv_i, input logic [1:0] fch_i);
    vec_t t;
    t.en = en_i; t.clr = clr_i; t.v = v_i; t.r = r_i; t.d = d_i;
    t.hs = hs_i; t.hsw = hs_i; t.pend = pend_i; t.eh = eh_i; t.et = et_i;
    t.ea = ea_i; t.fv = fv_i; t.fch = fch_i;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur_vec, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard (vec %0d): no expected entry", cur_vec);
      return;
    end
    e = exp_q.pop_front();
    chk("hs_cnt",        64'(hs_s),  64'(e.hs));
    chk("hs_cnt_wrap",   64'(hs_w),  64'(e.hsw));
    chk("pending",       64'(pend_s), 64'(e.pend));
    chk("err_hold",      64'(eh_s),  64'(e.eh));
    chk("err_timeout",   64'(et_s),  64'(e.et));
    chk("err_any",       64'(ea_s),  64'(e.ea));
    chk("first_err_vld", 64'(fv_s),  64'(e.fv));
    chk("first_err_ch",  64'(fch_s), 64'(e.fch));
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    en    = t.en;
    clr   = t.clr;
    valid = t.v;
    ready = t.r;
    data  = t.d;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    check_out();
    cur_vec++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hs"},   64'(hs_s),   64'd0);
    chk({tag, "_hsw"},  64'(hs_w),   64'd0);
    chk({tag, "_pend"}, 64'({pend_s, pend_w}), 64'd0);
    chk({tag, "_eh"},   64'({eh_s, eh_w}),     64'd0);
    chk({tag, "_et"},   64'({et_s, et_w}),     64'd0);
    chk({tag, "_misc"}, 64'({ea_s, ea_w, fv_s, fv_w, fch_s, fch_w}), 64'd0);
  endtask

  initial begin
    vec_t t;
    rst = 1'b1; en = 1'b0; clr = 1'b0; valid = '0; ready = '0; data = '0;

    // Ch0: five back-to-back handshakes, then idle
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(1, 0, 4'b0001, 4'b0001, 0, 12'(k), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 12'h005, 0, 0, 0, 0, 0, 0));
    // Ch1: three stalled edges with stable data, then accepted
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 4'b0010, 4'b0000, D1, 12'h005, 4'b0010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, D1, 12'h00D, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0,  12'h00D, 0, 0, 0, 0, 0, 0));
    // Ch2: stall then valid drop -> hold error, first error ch2; then clear
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0000, 0, 12'h00D, 4'b0100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 12'h00D, 0, 4'b0100, 0, 1, 1, 2));
    tbl.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 12'h000, 0, 0, 0, 0, 0, 0));
    // Ch3: timeout on the 4th stalled edge; later ch0 error keeps capture at 3
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 0,       4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 0, 4'b1001, 4'b0000, 0, 0, 4'b1001, 0,       4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0001, 4'b1000, 1, 1, 3));
    // Ch3 accepted; ch1 stalls; clr on a ch0 handshake edge; ch1 later accepted
    tbl.push_back(mk(1, 0, 4'b1000, 4'b1000, 0,  12'h200, 0,       4'b0001, 4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0000, D1, 12'h200, 4'b0010, 4'b0001, 4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 1, 4'b0011, 4'b0001, D1, 12'h000, 4'b0010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, D1, 12'h008, 0, 0, 0, 0, 0, 0));
    // en dropped mid-transaction, data changes, en back: fresh handshake, no error
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0000, D1,  12'h008, 4'b0010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0000, D1B, 12'h008, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0010, D1B, 12'h010, 0, 0, 0, 0, 0, 0));
    // Ch2: data changes while stalled -> hold error, re-latched, then accepted
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0000, D2A, 12'h010, 4'b0100, 0,       0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0000, D2B, 12'h010, 4'b0100, 4'b0100, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, D2B, 12'h050, 0,       4'b0100, 0, 1, 1, 2));
    // Simultaneous errors on ch1 and ch3: lowest index wins
    tbl.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0,       0,       0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1010, 4'b0000, 0, 0, 4'b1010, 0,       0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0,       4'b1010, 0, 1, 1, 1));

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Counter boundary: nine handshakes on 3-bit counters, saturating vs wrapping
    apply(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      t = mk(1, 0, 4'b0001, 4'b0001, 0, 12'((k > 7) ? 7 : k), 0, 0, 0, 0, 0, 0);
      t.hsw = 12'(k % 8);
      apply(t);
    end

    // Asynchronous reset mid-transaction, between clock edges
    t = mk(1, 0, 4'b0010, 4'b0000, D1, 12'h007, 4'b0010, 0, 0, 0, 0, 0);
    t.hsw = 12'h001;
    apply(t);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    valid = '0; ready = '0; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
